// File: rtl/entropy_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : entropy_ctrl_pkg
// Description : Shared state encoding and bitstream flag constants for the
//               entropy frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package entropy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RST   = 3'd4
  } state_t;

  localparam logic [2:0] FLAG_NONE     = 3'd0;
  localparam logic [2:0] FLAG_RUN_BASE = 3'd4;
  localparam logic [2:0] FLAG_RUN_MAX  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/bitstream_byte_count.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_byte_count
// Description : Decodes the encoder's 3-bit bitstream flag and run count into
//               the number of bytes emitted this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_byte_count
  import entropy_ctrl_pkg::*;
#(
  parameter int unsigned BITSTREAM_WIDTH = 8
) (
  input  logic [2:0]                 i_flag,
  input  logic [BITSTREAM_WIDTH-1:0] i_run,
  output logic [BITSTREAM_WIDTH:0]   o_bytes,
  output logic                       o_invalid
);

  localparam int unsigned c_cw = BITSTREAM_WIDTH + 1;

  always_comb begin
    o_bytes   = '0;
    o_invalid = 1'b0;
    if (i_flag == FLAG_NONE) begin
      o_bytes = '0;
    end else if (i_flag < FLAG_RUN_BASE) begin
      o_bytes = c_cw'(i_flag);
    end else if (i_flag == FLAG_RUN_BASE) begin
      o_invalid = 1'b1;
    end else begin
      // Run flags carry 1..3 literal bytes followed by the run.
      o_bytes = {1'b0, i_run} + c_cw'(i_flag - FLAG_RUN_BASE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/entropy_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : entropy_frame_ctrl
// Description : Frame sequencer driving entropy_encoder symbol inputs, flush
//               and reset, with per-frame symbol/byte counts.
//               Optional flush watchdog: ENTROPY_FRAME_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module entropy_frame_ctrl
  import entropy_ctrl_pkg::*;
#(
  parameter int unsigned RANGE_WIDTH     = 16,
  parameter int unsigned SYMBOL_WIDTH    = 4,
  parameter int unsigned BITSTREAM_WIDTH = 8,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned FLUSH_TIMEOUT   = 1024
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic [RANGE_WIDTH-1:0]     s_fl,
  input  logic [RANGE_WIDTH-1:0]     s_fh,
  input  logic [SYMBOL_WIDTH-1:0]    s_symbol,
  input  logic [SYMBOL_WIDTH:0]      s_nsyms,
  input  logic                       s_bool,
  output logic                       enc_reset,
  output logic                       enc_flag_first,
  output logic                       enc_final_flag,
  output logic [RANGE_WIDTH-1:0]     enc_fl,
  output logic [RANGE_WIDTH-1:0]     enc_fh,
  output logic [SYMBOL_WIDTH-1:0]    enc_symbol,
  output logic [SYMBOL_WIDTH:0]      enc_nsyms,
  output logic                       enc_bool,
  input  logic [2:0]                 enc_flag_bitstream,
  input  logic [BITSTREAM_WIDTH-1:0] enc_run_count,
  input  logic                       enc_flag_last,
  output logic                       frame_done,
  output logic [CNT_WIDTH-1:0]       frame_syms,
  output logic [CNT_WIDTH-1:0]       frame_bytes,
  output logic                       err_gap,
  output logic                       err_flag,
  output logic                       err_timeout
);

  localparam int unsigned c_sw = CNT_WIDTH + 1;

  state_t                      r_state;
  logic [RANGE_WIDTH-1:0]      r_enc_fl;
  logic [RANGE_WIDTH-1:0]      r_enc_fh;
  logic [SYMBOL_WIDTH-1:0]     r_enc_symbol;
  logic [SYMBOL_WIDTH:0]       r_enc_nsyms;
  logic                        r_enc_bool;
  logic                        r_flag_first;
  logic                        r_final;
  logic                        r_frame_done;
  logic [CNT_WIDTH-1:0]        r_frame_syms;
  logic [CNT_WIDTH-1:0]        r_frame_bytes;
  logic [CNT_WIDTH-1:0]        r_syms;
  logic [CNT_WIDTH-1:0]        r_bytes;
  logic                        r_err_gap;
  logic                        r_err_flag;

  logic                        w_ready;
  logic                        w_accept;
  logic                        w_decode_en;
  logic [BITSTREAM_WIDTH:0]    w_cycle_bytes;
  logic                        w_flag_inv;
  logic [CNT_WIDTH:0]          w_bytes_ext;
  logic [CNT_WIDTH-1:0]        w_bytes_sat;
  logic [CNT_WIDTH-1:0]        w_syms_inc;
  logic                        w_wd_fire;

  bitstream_byte_count #(
    .BITSTREAM_WIDTH (BITSTREAM_WIDTH)
  ) u_byte_count (
    .i_flag    (enc_flag_bitstream),
    .i_run     (enc_run_count),
    .o_bytes   (w_cycle_bytes),
    .o_invalid (w_flag_inv)
  );

  assign w_ready     = !top_reset && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_accept    = s_valid && w_ready;
  assign enc_reset   = top_reset || (r_state == ST_INIT) || (r_state == ST_RST);
  assign w_decode_en = !enc_reset;

  // Both running counters stick at all-ones rather than wrapping.
  assign w_bytes_ext = {1'b0, r_bytes} + c_sw'(w_cycle_bytes);
  assign w_bytes_sat = w_bytes_ext[CNT_WIDTH] ? '1 : w_bytes_ext[CNT_WIDTH-1:0];
  assign w_syms_inc  = (&r_syms) ? r_syms : r_syms + CNT_WIDTH'(1);

`ifdef ENTROPY_FRAME_CTRL_WATCHDOG_EN
  localparam int unsigned c_wd_w = $clog2(FLUSH_TIMEOUT + 1);

  logic [c_wd_w-1:0] r_wd;
  logic              r_err_timeout;

  assign w_wd_fire = (r_state == ST_FLUSH) && !enc_flag_last &&
                     (r_wd == c_wd_w'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      r_wd          <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wd <= (r_state == ST_FLUSH) ? r_wd + c_wd_w'(1) : '0;
      if (w_wd_fire) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_wd_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      r_state       <= ST_INIT;
      r_enc_fl      <= '0;
      r_enc_fh      <= '0;
      r_enc_symbol  <= '0;
      r_enc_nsyms   <= '0;
      r_enc_bool    <= 1'b0;
      r_flag_first  <= 1'b0;
      r_final       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_syms  <= '0;
      r_frame_bytes <= '0;
      r_syms        <= '0;
      r_bytes       <= '0;
      r_err_gap     <= 1'b0;
      r_err_flag    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_flag_first <= 1'b0;

      // Without an accept the encoder keeps seeing the previous symbol.
      if (w_accept) begin
        r_enc_fl     <= s_fl;
        r_enc_fh     <= s_fh;
        r_enc_symbol <= s_symbol;
        r_enc_nsyms  <= s_nsyms;
        r_enc_bool   <= s_bool;
        r_flag_first <= (r_state == ST_IDLE);
        r_syms       <= w_syms_inc;
      end

      if (w_decode_en) begin
        r_bytes <= w_bytes_sat;
        if (w_flag_inv) begin
          r_err_flag <= 1'b1;
        end
      end

      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= s_last ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!s_valid) begin
            r_err_gap <= 1'b1;
          end else if (s_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Frame results are latched entering RST so they line up with frame_done.
          if (enc_flag_last || w_wd_fire) begin
            r_state       <= ST_RST;
            r_final       <= 1'b0;
            r_frame_done  <= 1'b1;
            r_frame_syms  <= r_syms;
            r_frame_bytes <= w_bytes_sat;
          end else begin
            r_final <= 1'b1;
          end
        end
        ST_RST: begin
          r_state <= ST_IDLE;
          r_final <= 1'b0;
          r_syms  <= '0;
          r_bytes <= '0;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign s_ready        = w_ready;
  assign enc_flag_first = r_flag_first;
  assign enc_final_flag = r_final;
  assign enc_fl         = r_enc_fl;
  assign enc_fh         = r_enc_fh;
  assign enc_symbol     = r_enc_symbol;
  assign enc_nsyms      = r_enc_nsyms;
  assign enc_bool       = r_enc_bool;
  assign frame_done     = r_frame_done;
  assign frame_syms     = r_frame_syms;
  assign frame_bytes    = r_frame_bytes;
  assign err_gap        = r_err_gap;
  assign err_flag       = r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_entropy_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_entropy_frame_ctrl
// Description : Scoreboard bench for entropy_frame_ctrl with a stubbed encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entropy_frame_ctrl;

  logic        clk = 1'b0;
  logic        top_reset;
  logic        s_valid, s_ready, s_last, s_bool;
  logic [15:0] s_fl, s_fh;
  logic [3:0]  s_symbol;
  logic [4:0]  s_nsyms;
  logic        enc_reset, enc_flag_first, enc_final_flag, enc_bool;
  logic [15:0] enc_fl, enc_fh;
  logic [3:0]  enc_symbol;
  logic [4:0]  enc_nsyms;
  logic [2:0]  enc_flag_bitstream;
  logic [7:0]  enc_run_count;
  logic        enc_flag_last;
  logic        frame_done, err_gap, err_flag, err_timeout;
  logic [31:0] frame_syms, frame_bytes;

  typedef struct packed {
    logic [15:0] fl;
    logic [15:0] fh;
    logic [3:0]  sym;
    logic [4:0]  ns;
    logic        b;
    logic        first;
  } enc_exp_t;

  typedef struct packed {
    logic [31:0] syms;
    logic [31:0] bytes;
  } frame_exp_t;

  enc_exp_t   enc_q[$];
  frame_exp_t frame_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       in_frame = 1'b0;
  logic [3:0]  last_sym;
  logic [15:0] last_fl;

  entropy_frame_ctrl #(
    .RANGE_WIDTH     (16),
    .SYMBOL_WIDTH    (4),
    .BITSTREAM_WIDTH (8),
    .CNT_WIDTH       (32),
    .FLUSH_TIMEOUT   (8)
  ) dut (
    .top_clk            (clk),
    .top_reset          (top_reset),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_last             (s_last),
    .s_fl               (s_fl),
    .s_fh               (s_fh),
    .s_symbol           (s_symbol),
    .s_nsyms            (s_nsyms),
    .s_bool             (s_bool),
    .enc_reset          (enc_reset),
    .enc_flag_first     (enc_flag_first),
    .enc_final_flag     (enc_final_flag),
    .enc_fl             (enc_fl),
    .enc_fh             (enc_fh),
    .enc_symbol         (enc_symbol),
    .enc_nsyms          (enc_nsyms),
    .enc_bool           (enc_bool),
    .enc_flag_bitstream (enc_flag_bitstream),
    .enc_run_count      (enc_run_count),
    .enc_flag_last      (enc_flag_last),
    .frame_done         (frame_done),
    .frame_syms         (frame_syms),
    .frame_bytes        (frame_bytes),
    .err_gap            (err_gap),
    .err_flag           (err_flag),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic last);
    s_valid  = 1'b1;
    s_last   = last;
    s_fl     = 16'($urandom);
    s_fh     = 16'($urandom);
    s_symbol = 4'($urandom);
    s_nsyms  = 5'd16;
    s_bool   = 1'b0;
    last_sym = s_symbol;
    last_fl  = s_fl;
    tick();
    s_valid  = 1'b0;
    s_last   = 1'b0;
  endtask

  task automatic stub_cycle(input logic [2:0] f, input logic [7:0] r, input logic l);
    enc_flag_bitstream = f;
    enc_run_count      = r;
    enc_flag_last      = l;
    tick();
    enc_flag_bitstream = 3'd0;
    enc_run_count      = 8'd0;
    enc_flag_last      = 1'b0;
  endtask

  // Scoreboard: accepts predict next-cycle enc_* values; frames predict results.
  always @(negedge clk) begin
    enc_exp_t   e;
    frame_exp_t f;
    if (enc_q.size() > 0) begin
      e = enc_q.pop_front();
      check_val("enc_data", {enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool},
                {e.fl, e.fh, e.sym, e.ns, e.b});
      check_val("enc_flag_first", enc_flag_first, e.first);
    end
    if (top_reset) begin
      enc_q.delete();
      in_frame = 1'b0;
    end else if (s_valid && s_ready) begin
      e.fl    = s_fl;
      e.fh    = s_fh;
      e.sym   = s_symbol;
      e.ns    = s_nsyms;
      e.b     = s_bool;
      e.first = !in_frame;
      enc_q.push_back(e);
      in_frame = !s_last;
    end
    if (frame_done) begin
      if (frame_q.size() == 0) begin
        check_val("unexpected_frame_done", 1, 0);
      end else begin
        f = frame_q.pop_front();
        check_val("frame_syms", frame_syms, f.syms);
        check_val("frame_bytes", frame_bytes, f.bytes);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    top_reset = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_bool = 1'b0;
    s_fl = '0; s_fh = '0; s_symbol = '0; s_nsyms = '0;
    enc_flag_bitstream = '0; enc_run_count = '0; enc_flag_last = 1'b0;
    repeat (3) tick();

    check_val("rst_enc_reset", enc_reset, 1);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_final", enc_final_flag, 0);
    check_val("rst_frame_syms", frame_syms, 0);
    check_val("rst_errs", {err_gap, err_flag, err_timeout}, 0);

    top_reset = 1'b0;
    #1;
    check_val("init_enc_reset", enc_reset, 1);
    check_val("init_s_ready", s_ready, 0);
    tick();
    check_val("idle_enc_reset", enc_reset, 0);
    check_val("idle_s_ready", s_ready, 1);

    // Three-symbol frame: bytes 2 + (2+10) + (3+255) = 272.
    frame_q.push_back('{syms: 32'd3, bytes: 32'd272});
    send_sym(1'b0);
    send_sym(1'b0);
    send_sym(1'b1);
    check_val("flush_s_ready", s_ready, 0);
    check_val("final_t1", enc_final_flag, 0);
    stub_cycle(3'd2, 8'd0, 1'b0);
    check_val("final_t2", enc_final_flag, 1);
    stub_cycle(3'd6, 8'd10, 1'b0);
    stub_cycle(3'd0, 8'd0, 1'b0);
    stub_cycle(3'd0, 8'd0, 1'b0);
    stub_cycle(3'd7, 8'd255, 1'b1);
    check_val("rst_state_done", frame_done, 1);
    check_val("rst_state_enc_reset", enc_reset, 1);
    check_val("rst_state_final", enc_final_flag, 0);
    tick();
    check_val("post_done_pulse", frame_done, 0);
    check_val("post_syms_held", frame_syms, 3);
    check_val("post_bytes_held", frame_bytes, 272);
    check_val("post_enc_reset", enc_reset, 0);

    // Single-symbol frame skips RUN, then a second frame starts afresh.
    frame_q.push_back('{syms: 32'd1, bytes: 32'd1});
    send_sym(1'b1);
    check_val("single_no_run", s_ready, 0);
    stub_cycle(3'd1, 8'd0, 1'b1);
    check_val("single_done", frame_done, 1);
    tick();
    frame_q.push_back('{syms: 32'd2, bytes: 32'd0});
    send_sym(1'b0);
    send_sym(1'b1);
    stub_cycle(3'd0, 8'd0, 1'b1);
    check_val("second_done", frame_done, 1);
    tick();

    // Mid-frame gap and invalid flag 4.
    check_val("gap_pre", err_gap, 0);
    frame_q.push_back('{syms: 32'd2, bytes: 32'd3});
    send_sym(1'b0);
    tick();
    check_val("gap_err", err_gap, 1);
    check_val("gap_hold_sym", enc_symbol, last_sym);
    check_val("gap_hold_fl", enc_fl, last_fl);
    send_sym(1'b1);
    stub_cycle(3'd4, 8'd0, 1'b0);
    check_val("flag4_err", err_flag, 1);
    stub_cycle(3'd3, 8'd0, 1'b1);
    check_val("gap_frame_done", frame_done, 1);
    tick();
    check_val("gap_sticky", err_gap, 1);
    check_val("flag_sticky", err_flag, 1);

    // Reset during FLUSH aborts the frame without frame_done.
    send_sym(1'b1);
    stub_cycle(3'd2, 8'd0, 1'b0);
    check_val("abort_final_on", enc_final_flag, 1);
    top_reset = 1'b1;
    #1;
    check_val("abort_enc_reset", enc_reset, 1);
    tick();
    check_val("abort_final_off", enc_final_flag, 0);
    check_val("abort_no_done", frame_done, 0);
    check_val("abort_cnt_clear", {frame_syms, frame_bytes}, 0);
    check_val("abort_err_clear", {err_gap, err_flag}, 0);
    top_reset = 1'b0;
    tick();
    check_val("abort_idle_ready", s_ready, 1);
    frame_q.push_back('{syms: 32'd2, bytes: 32'd1});
    send_sym(1'b0);
    send_sym(1'b1);
    stub_cycle(3'd5, 8'd0, 1'b1);
    check_val("after_abort_done", frame_done, 1);
    tick();

`ifdef ENTROPY_FRAME_CTRL_WATCHDOG_EN
    frame_q.push_back('{syms: 32'd1, bytes: 32'd0});
    send_sym(1'b1);
    cnt = 0;
    while (!frame_done && cnt < 40) begin
      tick();
      cnt++;
    end
    check_val("wd_cycles", cnt, 8);
    check_val("wd_timeout", err_timeout, 1);
    tick();
`else
    cnt = 0;
    check_val("no_wd_timeout", err_timeout, cnt);
`endif

    repeat (2) tick();
    check_val("enc_q_drained", enc_q.size(), 0);
    check_val("frame_q_drained", frame_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
